usb_pulpino_mailbox: RTL and testbench

Byte-wide, FIFO-buffered mailbox between the USB register file and the PULPino GPIO port. The host side uses single-cycle push/pop strobes already in the PULPino clock domain. The PULPino side uses a toggle ("flicker") handshake on GPIO bits. It replaces the unbuffered single-register channel so the host can queue bursts without waiting for firmware polling.

---
 rtl/usb_pulpino_pkg.sv | 25 ++
 rtl/mb_sync_fifo.sv | 56 +++++
 rtl/usb_pulpino_mailbox.sv | 166 ++++++++++++++++
 tb/tb_usb_pulpino_mailbox.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pulpino_pkg.sv
// Shared types and constants for the USB <-> PULPino byte mailbox.
package usb_pulpino_pkg;

   typedef logic [7:0] byte_t;

   localparam int MB_DEPTH = 16;

   // Presenter side: one byte at a time is offered to firmware on p_rx_data.
   typedef enum logic {
      PRES_IDLE = 1'b0,
      PRES_WAIT = 1'b1
   } pres_state_t;

   // Capture side: HOLD parks one byte when P2H is full.
   typedef enum logic {
      CAP_IDLE = 1'b0,
      CAP_HOLD = 1'b1
   } cap_state_t;

   // Bit positions inside usb_err.
   localparam int ERR_H2P_OVF = 0;
   localparam int ERR_TX_OVF  = 1;
   localparam int ERR_PROTO   = 2;

endpackage

// File: rtl/mb_sync_fifo.sv
// Single-clock byte FIFO. A push into a full FIFO succeeds when a pop
// happens in the same cycle, so a queue can stream at full occupancy.
module mb_sync_fifo
   import usb_pulpino_pkg::*;
#(
   parameter  int DEPTH = MB_DEPTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  byte_t         i_din,
   input  logic          i_pop,
   output byte_t         o_head,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);

   byte_t         r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push_ok;
   logic          w_pop_ok;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_pop_ok  = i_pop & ~o_empty;
   assign w_push_ok = i_push & (~o_full | w_pop_ok);
   assign o_head    = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   // Storage, pointers (wrap naturally at DEPTH) and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/usb_pulpino_mailbox.sv
// Buffered byte mailbox between the USB register file (strobe side) and
// PULPino GPIO (toggle handshake side).
//
//  state      | meaning
//  PRES_IDLE  | no byte outstanding at firmware; pop H2P head when available
//  PRES_WAIT  | byte on p_rx_data, waiting for p_rx_ack to toggle
//  CAP_IDLE   | ready to take p_tx_data on a p_tx_toggle edge
//  CAP_HOLD   | P2H was full; byte parked in hold reg, ack withheld
module usb_pulpino_mailbox
   import usb_pulpino_pkg::*;
#(
   parameter  int DEPTH = MB_DEPTH,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          usb_wr_valid,
   input  logic [7:0]    usb_wr_data,
   output logic          usb_wr_full,
   input  logic          usb_rd_pop,
   output logic [7:0]    usb_rd_data,
   output logic          usb_rd_valid,
   output logic [CW-1:0] usb_h2p_count,
   output logic [CW-1:0] usb_p2h_count,
   output logic [2:0]    usb_err,
   input  logic          usb_err_clr,
   output logic [7:0]    p_rx_data,
   output logic          p_rx_toggle,
   input  logic          p_rx_ack,
   input  logic [7:0]    p_tx_data,
   input  logic          p_tx_toggle,
   output logic          p_tx_ack
);

   pres_state_t r_pres_st;
   cap_state_t  r_cap_st;
   logic        r_rx_ack_prev;
   logic        r_tx_tog_prev;
   byte_t       r_rx_data;
   logic        r_rx_toggle;
   logic        r_tx_ack;
   byte_t       r_hold;
   logic [2:0]  r_err;

   logic        w_rx_ack_edge;
   logic        w_tx_edge;
   logic        w_h2p_full;
   logic        w_h2p_empty;
   byte_t       w_h2p_head;
   logic        w_pres_pop;
   logic        w_p2h_full;
   logic        w_p2h_empty;
   logic        w_tx_space;
   logic        w_p2h_push;
   byte_t       w_p2h_din;
   logic [2:0]  w_err_set;

   assign w_rx_ack_edge = p_rx_ack ^ r_rx_ack_prev;
   assign w_tx_edge     = p_tx_toggle ^ r_tx_tog_prev;

   assign w_pres_pop = (r_pres_st == PRES_IDLE) & ~w_h2p_empty;

   // A same-cycle host pop frees a slot, so a full P2H still has room.
   assign w_tx_space = ~w_p2h_full | usb_rd_pop;
   assign w_p2h_push = (((r_cap_st == CAP_IDLE) & w_tx_edge) | (r_cap_st == CAP_HOLD))
                       & w_tx_space;
   assign w_p2h_din  = (r_cap_st == CAP_HOLD) ? r_hold : p_tx_data;

   assign w_err_set[ERR_H2P_OVF] = usb_wr_valid & w_h2p_full & ~w_pres_pop;
   assign w_err_set[ERR_TX_OVF]  = (r_cap_st == CAP_IDLE) & w_tx_edge & ~w_tx_space;
   assign w_err_set[ERR_PROTO]   = ((r_pres_st == PRES_IDLE) & w_rx_ack_edge)
                                 | ((r_cap_st == CAP_HOLD) & w_tx_edge);

   mb_sync_fifo #(.DEPTH(DEPTH)) u_h2p (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (usb_wr_valid),
      .i_din   (usb_wr_data),
      .i_pop   (w_pres_pop),
      .o_head  (w_h2p_head),
      .o_full  (w_h2p_full),
      .o_empty (w_h2p_empty),
      .o_count (usb_h2p_count)
   );

   mb_sync_fifo #(.DEPTH(DEPTH)) u_p2h (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_p2h_push),
      .i_din   (w_p2h_din),
      .i_pop   (usb_rd_pop),
      .o_head  (usb_rd_data),
      .o_full  (w_p2h_full),
      .o_empty (w_p2h_empty),
      .o_count (usb_p2h_count)
   );

   assign usb_wr_full  = w_h2p_full;
   assign usb_rd_valid = ~w_p2h_empty;
   assign usb_err      = r_err;
   assign p_rx_data    = r_rx_data;
   assign p_rx_toggle  = r_rx_toggle;
   assign p_tx_ack     = r_tx_ack;

   // Toggle history for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_ack_prev <= 1'b0;
         r_tx_tog_prev <= 1'b0;
      end else begin
         r_rx_ack_prev <= p_rx_ack;
         r_tx_tog_prev <= p_tx_toggle;
      end
   end

   // Presenter: hand one H2P byte at a time to firmware.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pres_st   <= PRES_IDLE;
         r_rx_data   <= '0;
         r_rx_toggle <= 1'b0;
      end else begin
         case (r_pres_st)
            PRES_IDLE: if (!w_h2p_empty) begin
               r_rx_data   <= w_h2p_head;
               r_rx_toggle <= ~r_rx_toggle;
               r_pres_st   <= PRES_WAIT;
            end
            PRES_WAIT: if (w_rx_ack_edge) r_pres_st <= PRES_IDLE;
            default:   r_pres_st <= PRES_IDLE;
         endcase
      end
   end

   // Capture: take firmware bytes into P2H, parking one when full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cap_st <= CAP_IDLE;
         r_hold   <= '0;
         r_tx_ack <= 1'b0;
      end else begin
         case (r_cap_st)
            CAP_IDLE: if (w_tx_edge) begin
               if (w_tx_space) begin
                  r_tx_ack <= ~r_tx_ack;
               end else begin
                  r_hold   <= p_tx_data;
                  r_cap_st <= CAP_HOLD;
               end
            end
            CAP_HOLD: if (w_tx_space) begin
               r_tx_ack <= ~r_tx_ack;
               r_cap_st <= CAP_IDLE;
            end
            default: r_cap_st <= CAP_IDLE;
         endcase
      end
   end

   // Sticky error flags; a same-cycle set wins over clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_err <= '0;
      else        r_err <= w_err_set | (r_err & {3{~usb_err_clr}});
   end

endmodule

// File: tb/tb_usb_pulpino_mailbox.sv
// Directed bench for usb_pulpino_mailbox. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_usb_pulpino_mailbox;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       usb_wr_valid = 1'b0;
   logic [7:0] usb_wr_data = 8'h00;
   logic       usb_wr_full;
   logic       usb_rd_pop = 1'b0;
   logic [7:0] usb_rd_data;
   logic       usb_rd_valid;
   logic [4:0] usb_h2p_count;
   logic [4:0] usb_p2h_count;
   logic [2:0] usb_err;
   logic       usb_err_clr = 1'b0;
   logic [7:0] p_rx_data;
   logic       p_rx_toggle;
   logic       p_rx_ack = 1'b0;
   logic [7:0] p_tx_data = 8'h00;
   logic       p_tx_toggle = 1'b0;
   logic       p_tx_ack;

   int   checks = 0;
   int   errors = 0;
   logic exp_rx_tog = 1'b0;
   logic exp_tx_ack = 1'b0;

   always #5 clk = ~clk;

   usb_pulpino_mailbox #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .usb_wr_valid  (usb_wr_valid),
      .usb_wr_data   (usb_wr_data),
      .usb_wr_full   (usb_wr_full),
      .usb_rd_pop    (usb_rd_pop),
      .usb_rd_data   (usb_rd_data),
      .usb_rd_valid  (usb_rd_valid),
      .usb_h2p_count (usb_h2p_count),
      .usb_p2h_count (usb_p2h_count),
      .usb_err       (usb_err),
      .usb_err_clr   (usb_err_clr),
      .p_rx_data     (p_rx_data),
      .p_rx_toggle   (p_rx_toggle),
      .p_rx_ack      (p_rx_ack),
      .p_tx_data     (p_tx_data),
      .p_tx_toggle   (p_tx_toggle),
      .p_tx_ack      (p_tx_ack)
   );

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (usb_h2p_count !== 5'd0) begin errors++; $display("FAIL reset_h2p_count got %0d exp 0", usb_h2p_count); end
      checks++; if (usb_p2h_count !== 5'd0) begin errors++; $display("FAIL reset_p2h_count got %0d exp 0", usb_p2h_count); end
      checks++; if (usb_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", usb_rd_valid); end
      checks++; if (usb_wr_full !== 1'b0) begin errors++; $display("FAIL reset_wr_full got %b exp 0", usb_wr_full); end
      checks++; if (usb_err !== 3'b000) begin errors++; $display("FAIL reset_err got %b exp 000", usb_err); end
      checks++; if (p_rx_toggle !== 1'b0 || p_tx_ack !== 1'b0) begin errors++; $display("FAIL reset_toggles got %b%b exp 00", p_rx_toggle, p_tx_ack); end
      checks++; if (p_rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", p_rx_data); end
      rst_n = 1'b1;
      @(negedge clk);
      exp_rx_tog = 1'b0;
      exp_tx_ack = 1'b0;
   endtask

   task automatic test_single_rx();
      usb_wr_data = 8'hA5; usb_wr_valid = 1'b1;
      @(negedge clk);
      usb_wr_valid = 1'b0;
      checks++; if (usb_h2p_count !== 5'd1) begin errors++; $display("FAIL rx1_count_n1 got %0d exp 1", usb_h2p_count); end
      checks++; if (p_rx_toggle !== exp_rx_tog) begin errors++; $display("FAIL rx1_toggle_n1 got %b exp %b", p_rx_toggle, exp_rx_tog); end
      @(negedge clk);
      exp_rx_tog = ~exp_rx_tog;
      checks++; if (p_rx_data !== 8'hA5) begin errors++; $display("FAIL rx1_data got %h exp a5", p_rx_data); end
      checks++; if (p_rx_toggle !== exp_rx_tog) begin errors++; $display("FAIL rx1_toggle_n2 got %b exp %b", p_rx_toggle, exp_rx_tog); end
      checks++; if (usb_h2p_count !== 5'd0) begin errors++; $display("FAIL rx1_count_n2 got %0d exp 0", usb_h2p_count); end
      p_rx_ack = ~p_rx_ack;
      repeat (2) @(negedge clk);
      checks++; if (p_rx_toggle !== exp_rx_tog) begin errors++; $display("FAIL rx1_toggle_after_ack got %b exp %b", p_rx_toggle, exp_rx_tog); end
      checks++; if (usb_h2p_count !== 5'd0) begin errors++; $display("FAIL rx1_count_after_ack got %0d exp 0", usb_h2p_count); end
      checks++; if (usb_err !== 3'b000) begin errors++; $display("FAIL rx1_err got %b exp 000", usb_err); end
   endtask

   task automatic test_burst();
      for (int i = 0; i <= 16; i++) begin
         usb_wr_data = 8'(i); usb_wr_valid = 1'b1;
         @(negedge clk);
      end
      usb_wr_valid = 1'b0;
      exp_rx_tog = ~exp_rx_tog;
      checks++; if (usb_h2p_count !== 5'd16) begin errors++; $display("FAIL burst_count got %0d exp 16", usb_h2p_count); end
      checks++; if (usb_wr_full !== 1'b1) begin errors++; $display("FAIL burst_full got %b exp 1", usb_wr_full); end
      checks++; if (usb_err !== 3'b000) begin errors++; $display("FAIL burst_no_ovf got %b exp 000", usb_err); end
      checks++; if (p_rx_data !== 8'h00 || p_rx_toggle !== exp_rx_tog) begin errors++; $display("FAIL burst_first got %h/%b exp 00/%b", p_rx_data, p_rx_toggle, exp_rx_tog); end
      // Push into a full FIFO with the presenter stalled: dropped.
      usb_wr_data = 8'h99; usb_wr_valid = 1'b1;
      @(negedge clk);
      usb_wr_valid = 1'b0;
      checks++; if (usb_h2p_count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", usb_h2p_count); end
      checks++; if (usb_err !== 3'b001) begin errors++; $display("FAIL ovf_err got %b exp 001", usb_err); end
      usb_err_clr = 1'b1;
      @(negedge clk);
      usb_err_clr = 1'b0;
      checks++; if (usb_err !== 3'b000) begin errors++; $display("FAIL ovf_clr got %b exp 000", usb_err); end
      // Push on the same cycle the presenter pops a full FIFO: accepted.
      p_rx_ack = ~p_rx_ack;
      @(negedge clk);
      usb_wr_data = 8'h11; usb_wr_valid = 1'b1;
      @(negedge clk);
      usb_wr_valid = 1'b0;
      exp_rx_tog = ~exp_rx_tog;
      checks++; if (usb_h2p_count !== 5'd16) begin errors++; $display("FAIL fullpush_count got %0d exp 16", usb_h2p_count); end
      checks++; if (usb_err !== 3'b000) begin errors++; $display("FAIL fullpush_err got %b exp 000", usb_err); end
      checks++; if (p_rx_data !== 8'h01 || p_rx_toggle !== exp_rx_tog) begin errors++; $display("FAIL fullpush_present got %h/%b exp 01/%b", p_rx_data, p_rx_toggle, exp_rx_tog); end
      for (int i = 2; i <= 17; i++) begin
         p_rx_ack = ~p_rx_ack;
         repeat (2) @(negedge clk);
         exp_rx_tog = ~exp_rx_tog;
         checks++; if (p_rx_data !== 8'(i) || p_rx_toggle !== exp_rx_tog) begin errors++; $display("FAIL drain_%0d got %h/%b exp %h/%b", i, p_rx_data, p_rx_toggle, 8'(i), exp_rx_tog); end
      end
      checks++; if (usb_h2p_count !== 5'd0 || usb_wr_full !== 1'b0) begin errors++; $display("FAIL drain_empty got %0d/%b exp 0/0", usb_h2p_count, usb_wr_full); end
      p_rx_ack = ~p_rx_ack;
      repeat (2) @(negedge clk);
      checks++; if (p_rx_toggle !== exp_rx_tog) begin errors++; $display("FAIL drain_idle_toggle got %b exp %b", p_rx_toggle, exp_rx_tog); end
   endtask

   task automatic test_tx_single();
      p_tx_data = 8'h3C; p_tx_toggle = ~p_tx_toggle;
      @(negedge clk);
      exp_tx_ack = ~exp_tx_ack;
      checks++; if (p_tx_ack !== exp_tx_ack) begin errors++; $display("FAIL tx1_ack got %b exp %b", p_tx_ack, exp_tx_ack); end
      checks++; if (usb_rd_data !== 8'h3C || usb_rd_valid !== 1'b1) begin errors++; $display("FAIL tx1_head got %h/%b exp 3c/1", usb_rd_data, usb_rd_valid); end
      checks++; if (usb_p2h_count !== 5'd1) begin errors++; $display("FAIL tx1_count got %0d exp 1", usb_p2h_count); end
      usb_rd_pop = 1'b1;
      @(negedge clk);
      usb_rd_pop = 1'b0;
      checks++; if (usb_rd_valid !== 1'b0 || usb_p2h_count !== 5'd0) begin errors++; $display("FAIL tx1_pop got %b/%0d exp 0/0", usb_rd_valid, usb_p2h_count); end
   endtask

   task automatic test_tx_overflow();
      for (int i = 0; i < 16; i++) begin
         p_tx_data = 8'h40 + 8'(i); p_tx_toggle = ~p_tx_toggle;
         @(negedge clk);
         exp_tx_ack = ~exp_tx_ack;
      end
      checks++; if (usb_p2h_count !== 5'd16 || p_tx_ack !== exp_tx_ack) begin errors++; $display("FAIL txfill got %0d/%b exp 16/%b", usb_p2h_count, p_tx_ack, exp_tx_ack); end
      p_tx_data = 8'h77; p_tx_toggle = ~p_tx_toggle;
      @(negedge clk);
      checks++; if (p_tx_ack !== exp_tx_ack) begin errors++; $display("FAIL txhold_ack got %b exp %b", p_tx_ack, exp_tx_ack); end
      checks++; if (usb_err !== 3'b010) begin errors++; $display("FAIL txhold_err got %b exp 010", usb_err); end
      // Extra toggle while holding is a protocol error; held byte kept.
      p_tx_toggle = ~p_tx_toggle;
      @(negedge clk);
      checks++; if (usb_err !== 3'b110 || p_tx_ack !== exp_tx_ack) begin errors++; $display("FAIL txhold_proto got %b/%b exp 110/%b", usb_err, p_tx_ack, exp_tx_ack); end
      usb_rd_pop = 1'b1;
      @(negedge clk);
      usb_rd_pop = 1'b0;
      exp_tx_ack = ~exp_tx_ack;
      checks++; if (p_tx_ack !== exp_tx_ack) begin errors++; $display("FAIL txrelease_ack got %b exp %b", p_tx_ack, exp_tx_ack); end
      checks++; if (usb_p2h_count !== 5'd16 || usb_rd_data !== 8'h41) begin errors++; $display("FAIL txrelease_fifo got %0d/%h exp 16/41", usb_p2h_count, usb_rd_data); end
      usb_err_clr = 1'b1;
      @(negedge clk);
      usb_err_clr = 1'b0;
      checks++; if (usb_err !== 3'b000) begin errors++; $display("FAIL tx_err_clr got %b exp 000", usb_err); end
      for (int i = 1; i < 16; i++) begin
         checks++; if (usb_rd_data !== 8'h40 + 8'(i)) begin errors++; $display("FAIL txread_%0d got %h exp %h", i, usb_rd_data, 8'h40 + 8'(i)); end
         usb_rd_pop = 1'b1;
         @(negedge clk);
         usb_rd_pop = 1'b0;
      end
      checks++; if (usb_rd_data !== 8'h77 || usb_rd_valid !== 1'b1) begin errors++; $display("FAIL txread_last got %h/%b exp 77/1", usb_rd_data, usb_rd_valid); end
      usb_rd_pop = 1'b1;
      @(negedge clk);
      usb_rd_pop = 1'b0;
      checks++; if (usb_rd_valid !== 1'b0 || p_tx_ack !== exp_tx_ack) begin errors++; $display("FAIL txread_empty got %b/%b exp 0/%b", usb_rd_valid, p_tx_ack, exp_tx_ack); end
   endtask

   task automatic test_spurious_ack();
      p_rx_ack = ~p_rx_ack;
      @(negedge clk);
      checks++; if (usb_err !== 3'b100 || p_rx_toggle !== exp_rx_tog) begin errors++; $display("FAIL spurious got %b/%b exp 100/%b", usb_err, p_rx_toggle, exp_rx_tog); end
      usb_err_clr = 1'b1;
      @(negedge clk);
      usb_err_clr = 1'b0;
      checks++; if (usb_err !== 3'b000) begin errors++; $display("FAIL spurious_clr got %b exp 000", usb_err); end
      // Same-cycle set and clear: the set wins.
      p_rx_ack = ~p_rx_ack; usb_err_clr = 1'b1;
      @(negedge clk);
      usb_err_clr = 1'b0;
      checks++; if (usb_err !== 3'b100) begin errors++; $display("FAIL set_over_clr got %b exp 100", usb_err); end
      usb_err_clr = 1'b1;
      @(negedge clk);
      usb_err_clr = 1'b0;
      checks++; if (usb_err !== 3'b000) begin errors++; $display("FAIL set_over_clr_clear got %b exp 000", usb_err); end
   endtask

   task automatic test_reset_mid();
      p_tx_data = 8'hE1; p_tx_toggle = ~p_tx_toggle;
      for (int i = 0; i < 6; i++) begin
         usb_wr_data = 8'hB0 + 8'(i); usb_wr_valid = 1'b1;
         @(negedge clk);
      end
      usb_wr_valid = 1'b0;
      exp_rx_tog = ~exp_rx_tog;
      exp_tx_ack = ~exp_tx_ack;
      checks++; if (usb_h2p_count !== 5'd5 || usb_rd_valid !== 1'b1) begin errors++; $display("FAIL premid got %0d/%b exp 5/1", usb_h2p_count, usb_rd_valid); end
      checks++; if (p_rx_data !== 8'hB0 || p_rx_toggle !== exp_rx_tog || p_tx_ack !== exp_tx_ack) begin errors++; $display("FAIL premid_handshake got %h/%b/%b exp b0/%b/%b", p_rx_data, p_rx_toggle, p_tx_ack, exp_rx_tog, exp_tx_ack); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (usb_h2p_count !== 5'd0 || usb_p2h_count !== 5'd0) begin errors++; $display("FAIL midrst_counts got %0d/%0d exp 0/0", usb_h2p_count, usb_p2h_count); end
      checks++; if (p_rx_toggle !== 1'b0 || p_tx_ack !== 1'b0) begin errors++; $display("FAIL midrst_toggles got %b%b exp 00", p_rx_toggle, p_tx_ack); end
      checks++; if (usb_rd_valid !== 1'b0 || p_rx_data !== 8'h00) begin errors++; $display("FAIL midrst_outputs got %b/%h exp 0/00", usb_rd_valid, p_rx_data); end
      p_rx_ack = 1'b0; p_tx_toggle = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_rx_tog = 1'b0;
      exp_tx_ack = 1'b0;
      @(negedge clk);
      usb_wr_data = 8'hC3; usb_wr_valid = 1'b1;
      @(negedge clk);
      usb_wr_valid = 1'b0;
      @(negedge clk);
      exp_rx_tog = ~exp_rx_tog;
      checks++; if (p_rx_data !== 8'hC3 || p_rx_toggle !== exp_rx_tog) begin errors++; $display("FAIL postrst got %h/%b exp c3/%b", p_rx_data, p_rx_toggle, exp_rx_tog); end
   endtask

   initial begin
      test_reset();
      test_single_rx();
      test_burst();
      test_tx_single();
      test_tx_overflow();
      test_spurious_ack();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
